// File: rtl/comp_pkg.sv
// ============================================================================
// Module   : comp_pkg
// Purpose  : Shared state encodings and index-width helper for comp_sort_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package comp_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_SORT = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // A two-entry buffer still needs one index bit.
   function automatic int idx_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comp.sv
// ============================================================================
// Module   : comp
// Purpose  : Combinational unsigned magnitude comparator (gt / eq / lt).
// Revision : 1.0
// ============================================================================
`default_nettype none

module comp #(
   parameter int N = 8
) (
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   assign gt = (in0 >  in1);
   assign eq = (in0 == in1);
   assign lt = (in0 <  in1);

endmodule

`default_nettype wire

// File: rtl/comp_sort_ctrl.sv
// ============================================================================
// Module   : comp_sort_ctrl
// Purpose  : Loads DEPTH words, bubble-sorts them in place with one shared
//            comparator (one compare per clock), then streams them out ascending.
// Revision : 1.0
// ============================================================================
`default_nettype none

module comp_sort_ctrl
   import comp_pkg::*;
#(
   parameter int N     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int IDX_W = idx_width(DEPTH);

   localparam logic [IDX_W-1:0] c_one       = IDX_W'(1);
   localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] c_last_pass = IDX_W'(DEPTH - 2);

   state_t           state_q,     state_d;
   logic [N-1:0]     mem_q [DEPTH];
   logic [N-1:0]     mem_d [DEPTH];
   logic [IDX_W-1:0] wr_idx_q,    wr_idx_d;
   logic [IDX_W-1:0] rd_idx_q,    rd_idx_d;
   logic [IDX_W-1:0] pass_q,      pass_d;
   logic [IDX_W-1:0] cmp_idx_q,   cmp_idx_d;
   logic             swapped_q,   swapped_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q,  out_last_d;
   logic             busy_q,      busy_d;
   logic [N-1:0]     out_data_q,  out_data_d;

   logic [IDX_W-1:0] w_cmp_nxt;
   logic [N-1:0]     w_a;
   logic [N-1:0]     w_b;
   logic             w_gt;
   logic             w_eq;
   logic             w_lt;
   logic             w_pass_end;
   logic             w_unused_cmp;

   assign w_cmp_nxt    = cmp_idx_q + c_one;
   assign w_a          = mem_q[cmp_idx_q];
   assign w_b          = mem_q[w_cmp_nxt];
   assign w_pass_end   = (cmp_idx_q == (c_last_pass - pass_q));
   // Only gt steers the sort; strict greater-than keeps equal words in order.
   assign w_unused_cmp = w_eq ^ w_lt;

   comp #(
      .N (N)
   ) u_comp (
      .in0 (w_a),
      .in1 (w_b),
      .gt  (w_gt),
      .eq  (w_eq),
      .lt  (w_lt)
   );

   always_comb begin
      state_d   = state_q;
      mem_d     = mem_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      pass_d    = pass_q;
      cmp_idx_d = cmp_idx_q;
      swapped_d = swapped_q;

      case (state_q)
         ST_LOAD: begin
            if (in_valid && in_ready_q) begin
               mem_d[wr_idx_q] = in_data;
               if (wr_idx_q == c_last_idx) begin
                  wr_idx_d  = '0;
                  pass_d    = '0;
                  cmp_idx_d = '0;
                  swapped_d = 1'b0;
                  state_d   = ST_SORT;
               end else begin
                  wr_idx_d = wr_idx_q + c_one;
               end
            end
         end
         ST_SORT: begin
            if (w_gt) begin
               mem_d[cmp_idx_q] = w_b;
               mem_d[w_cmp_nxt] = w_a;
            end
            if (w_pass_end) begin
               if (!(swapped_q || w_gt) || (pass_q == c_last_pass)) begin
                  rd_idx_d = '0;
                  state_d  = ST_OUT;
               end else begin
                  pass_d    = pass_q + c_one;
                  cmp_idx_d = '0;
                  swapped_d = 1'b0;
               end
            end else begin
               cmp_idx_d = w_cmp_nxt;
               swapped_d = swapped_q | w_gt;
            end
         end
         ST_OUT: begin
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  rd_idx_d = '0;
                  state_d  = ST_LOAD;
               end else begin
                  rd_idx_d = rd_idx_q + c_one;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase

      // Outputs are registered from the next-state view so they line up with state_q.
      in_ready_d  = (state_d == ST_LOAD);
      out_valid_d = (state_d == ST_OUT);
      busy_d      = (state_d != ST_LOAD);
      out_last_d  = (state_d == ST_OUT) && (rd_idx_d == c_last_idx);
      out_data_d  = (state_d == ST_OUT) ? mem_d[rd_idx_d] : out_data_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         pass_q      <= '0;
         cmp_idx_q   <= '0;
         swapped_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         pass_q      <= pass_d;
         cmp_idx_q   <= cmp_idx_d;
         swapped_q   <= swapped_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_comp_sort_ctrl.sv
// ============================================================================
// Module   : tb_comp_sort_ctrl
// Purpose  : Self-checking bench for comp_sort_ctrl against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_comp_sort_ctrl;

   localparam int N     = 8;
   localparam int DEPTH = 8;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic [N-1:0] in_data   = '0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [N-1:0] out_data;
   logic         out_last;
   logic         busy;

   always #5 clk = ~clk;

   comp_sort_ctrl #(
      .N     (N),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   int           n_cmp    = 0;
   int           n_err    = 0;
   int           sort_cyc = 0;
   int           swap_cnt = 0;
   bit           mon_en   = 1'b0;
   logic [N-1:0] batch [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SORT cycles are the ones with busy high and no output offered.
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy && !out_valid) begin
            sort_cyc++;
            if (dut.w_gt) swap_cnt++;
         end
         check("ready_vs_busy", in_ready, !busy);
      end
   end

   // Bubble-sort facts: swaps = strict inversions; passes = 1 + max count of
   // larger words left of any word, capped at DEPTH-1; pass p costs DEPTH-1-p.
   task automatic model(output int exp_cyc, output int exp_swp);
      int m, g, passes;
      m = 0;
      exp_swp = 0;
      for (int k = 0; k < DEPTH; k++) begin
         g = 0;
         for (int j = 0; j < k; j++) if (batch[j] > batch[k]) g++;
         exp_swp += g;
         if (g > m) m = g;
      end
      passes  = (m + 1 < DEPTH - 1) ? m + 1 : DEPTH - 1;
      exp_cyc = 0;
      for (int p = 0; p < passes; p++) exp_cyc += DEPTH - 1 - p;
   endtask

   task automatic load_batch();
      int wd;
      sort_cyc = 0;
      swap_cnt = 0;
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1;
         in_data  = batch[k];
         wd = 0;
         while (!in_ready && wd < 300) begin
            @(posedge clk); #1;
            wd++;
         end
         if (!in_ready) begin
            check("load_timeout", 0, 1);
            return;
         end
         @(posedge clk); #1;
      end
      // Keep offering junk while busy; none of it may be taken.
      in_valid = 1'b1;
      in_data  = N'($urandom);
   endtask

   task automatic unload_check(input bit rnd, input string tag);
      int           q[$];
      int           got, wd, ec, es;
      logic [N-1:0] hold_d;
      logic         hold_l;
      bit           hold;
      for (int k = 0; k < DEPTH; k++) q.push_back(int'(batch[k]));
      q.sort();
      model(ec, es);
      got  = 0;
      wd   = 0;
      hold = 1'b0;
      while (got < DEPTH && wd < 3000) begin
         out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         in_data   = N'($urandom);
         if (hold) begin
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_data"},  out_data,  hold_d);
            check({tag, "_hold_last"},  out_last,  hold_l);
         end
         if (out_valid && out_ready) begin
            check({tag, "_data"}, out_data, q[got]);
            check({tag, "_last"}, out_last, (got == DEPTH - 1));
            got++;
            hold = 1'b0;
         end else if (out_valid) begin
            hold   = 1'b1;
            hold_d = out_data;
            hold_l = out_last;
         end
         @(posedge clk); #1;
         wd++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (got < DEPTH) check({tag, "_out_timeout"}, got, DEPTH);
      check({tag, "_sort_cycles"}, sort_cyc, ec);
      check({tag, "_swaps"},       swap_cnt, es);
      check({tag, "_end_ready"},   in_ready,  1);
      check({tag, "_end_valid"},   out_valid, 0);
      check({tag, "_end_busy"},    busy,      0);
   endtask

   initial begin
      int wd;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",   in_ready,  1);
      check("rst_out_valid",  out_valid, 0);
      check("rst_out_last",   out_last,  0);
      check("rst_busy",       busy,      0);
      check("rst_odata_x",    $isunknown(out_data), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int k = 0; k < DEPTH; k++) batch[k] = N'(k + 1);
      load_batch();
      unload_check(1'b0, "t1_sorted");

      for (int k = 0; k < DEPTH; k++) batch[k] = N'(DEPTH - k);
      load_batch();
      unload_check(1'b0, "t2_reverse");

      batch = '{8'd5, 8'd3, 8'd5, 8'd3, 8'hFF, 8'd0, 8'd3, 8'd5};
      load_batch();
      unload_check(1'b0, "t3_dups");

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < DEPTH; k++)
            batch[k] = (r[0]) ? N'($urandom) : N'($urandom_range(0, 7));
         load_batch();
         unload_check(1'b1, "t4_random");
      end

      for (int k = 0; k < DEPTH; k++) batch[k] = N'(DEPTH - k);
      load_batch();
      wd = 0;
      while (sort_cyc < 15 && wd < 200) begin
         @(posedge clk); #1;
         wd++;
      end
      check("t5_reached_pass2", (sort_cyc >= 15), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_busy",  busy,      0);
      check("t5_rst_ready", in_ready,  1);
      batch = '{8'd4, 8'd1, 8'd3, 8'd2, 8'd8, 8'd7, 8'd6, 8'd5};
      load_batch();
      unload_check(1'b1, "t5_after_rst");

      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < DEPTH; k++) batch[k] = N'($urandom);
         load_batch();
         unload_check(1'b1, (b == 0) ? "t6_first" : "t6_second");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
